vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in clocks.
- H_SYNC, 96, horizontal sync width in clocks.
- H_BP, 48, horizontal back porch in clocks.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, sync active level (0 = active-low).
- PIPE_DLY, 3, clocks from address-side timing to display-side outputs.

REQ-002 Ports, one per line: name, direction, width, meaning.
- vga_clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pixel_x  out  10  current horizontal count (P0 stage).
- pixel_y  out  10  current vertical count (P0 stage).
- vga_valid_pre3  out  1  P0 pixel lies in the active region; leads vga_de by PIPE_DLY clocks.
- frame_start  out  1  one-cycle pulse at P0 pixel (0,0).
- vga_de  out  1  display-side data enable.
- vga_hsync  out  1  display-side horizontal sync.
- vga_vsync  out  1  display-side vertical sync.

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). All counts are 10-bit unsigned.
REQ-004 pixel_x shall increment by 1 every vga_clk. After H_TOTAL-1 it shall wrap to 0.
REQ-005 pixel_y shall increment only on the cycle pixel_x wraps. After V_TOTAL-1 it shall wrap to 0 on that same cycle, so (H_TOTAL-1,V_TOTAL-1) is followed by (0,0).
REQ-006 vga_valid_pre3 shall be 1 exactly when pixel_x<H_ACTIVE and pixel_y<V_ACTIVE, in the same cycle as those counter values. It shall be 0 in every other cycle.
REQ-007 frame_start shall be 1 exactly in the cycles where pixel_x==0 and pixel_y==0, and 0 otherwise.
REQ-008 P0 hsync shall be active (level SYNC_POL) when H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751), and inactive otherwise.
REQ-009 P0 vsync shall be active when V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491), for all pixel_x on those lines, and inactive otherwise.
REQ-010 vga_de, vga_hsync and vga_vsync shall equal P0 valid, P0 hsync and P0 vsync delayed by exactly PIPE_DLY vga_clk cycles through registers.
REQ-011 All outputs shall be registered. There shall be no combinational path from any input to any output.
REQ-012 Each frame shall contain exactly H_ACTIVE*V_ACTIVE = 307200 vga_valid_pre3 cycles. Each active line shall have exactly 640 contiguous valid cycles.
REQ-013 The block has no stall or enable. The timing is free-running and there is no back-pressure from downstream.

Reset
REQ-014 While rst_n=0 (asynchronous assertion), every output shall hold its reset value:
- pixel_x = H_TOTAL-1 (799); pixel_y = V_TOTAL-1 (524).
- vga_valid_pre3 = 0; frame_start = 0; vga_de = 0.
- vga_hsync and vga_vsync at the inactive level (1 when SYNC_POL=0).
REQ-015 All PIPE_DLY delay-stage registers shall reset to de=0 and syncs inactive, so that no spurious de or sync appears during the first PIPE_DLY cycles after release.
REQ-016 On the first vga_clk edge after rst_n deasserts:
- pixel_x=0, pixel_y=0.
- vga_valid_pre3=1, frame_start=1.
REQ-017 Reset asserted mid-frame shall abort the frame immediately. Restart after release shall follow REQ-016 with no partial-frame state retained.

Verification
REQ-018 The bench shall cover these directed scenarios:
- Reset release: hold rst_n=0 for 5 clocks -> outputs 799/524/0/0/0, hsync=vsync=1. First edge after release -> (0,0), valid_pre3=1, frame_start=1. vga_de first goes 1 exactly 3 clocks later.
- Full frame: run 420000 clocks -> exactly 307200 valid_pre3 cycles. frame_start pulses once every 420000 clocks. Every line has 640 contiguous valid cycles starting at pixel_x=0.
- Horizontal sync: pixel_x reaches 656 -> vga_hsync falls 3 clocks later, stays low 96 clocks, and rises 3 clocks after pixel_x==752.
- Vertical sync and wrap: pixel_y=490 at pixel_x=0 -> vga_vsync low 3 clocks later for 1600 clocks. Transition (799,524) -> (0,0) occurs with pixel_y wrap and frame_start in the same cycle.
- Pipeline alignment: across a full frame, vga_de(t) == vga_valid_pre3(t-3) in every cycle. The count of valid_pre3 cycles equals the number of addresses a downstream read-address counter would consume (307200) before its wrap.
- Mid-frame reset: assert rst_n at (300,200) with de=1 -> de=0 and syncs inactive in the same cycle (asynchronous). Release -> restart at (0,0) per REQ-016.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing generator.
// A free-running pixel/line counter pair (P0 stage) supplies the read-address
// side with coordinates, an active-region flag and a frame pulse. The same
// P0 timing, delayed PIPE_DLY clocks, drives the display-side de/hsync/vsync
// so that they line up with pixel data coming out of a PIPE_DLY-deep
// fetch pipeline.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int PIPE_DLY = 3
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       vga_valid_pre3,
  output logic       frame_start,
  output logic       vga_de,
  output logic       vga_hsync,
  output logic       vga_vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 10-bit versions of the boundaries so every compare is width-matched.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ACT  = (SYNC_POL != 0);
  localparam logic SYNC_IDLE = !SYNC_ACT;

  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       valid_next;
  logic       fs_next;
  logic       hs_next;
  logic       vs_next;

  // P0 sync levels, registered alongside the counters.
  logic       hs_p0;
  logic       vs_p0;

  // Delay line for the display-side signals; bit PIPE_DLY-1 is the output.
  logic [PIPE_DLY-1:0] de_pipe;
  logic [PIPE_DLY-1:0] hs_pipe;
  logic [PIPE_DLY-1:0] vs_pipe;
  logic [PIPE_DLY-1:0] de_in;
  logic [PIPE_DLY-1:0] hs_in;
  logic [PIPE_DLY-1:0] vs_in;

  // Next counter position and the flags that describe it. Flags are computed
  // from the next position so that, once registered, they sit in the same
  // cycle as the counter value they describe.
  always_comb begin
    x_next = pixel_x + 10'd1;
    y_next = pixel_y;
    if (pixel_x == H_LAST) begin
      x_next = '0;
      if (pixel_y == V_LAST) begin
        y_next = '0;
      end else begin
        y_next = pixel_y + 10'd1;
      end
    end
    valid_next = (x_next < H_ACT) && (y_next < V_ACT);
    fs_next    = (x_next == 10'd0) && (y_next == 10'd0);
    hs_next    = ((x_next >= HS_START) && (x_next < HS_END)) ? SYNC_ACT : SYNC_IDLE;
    vs_next    = ((y_next >= VS_START) && (y_next < VS_END)) ? SYNC_ACT : SYNC_IDLE;
  end

  // P0 counters and flags; reset parks the counters on the last pixel so the
  // first clock after release lands on (0,0).
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x        <= H_LAST;
      pixel_y        <= V_LAST;
      vga_valid_pre3 <= 1'b0;
      frame_start    <= 1'b0;
      hs_p0          <= SYNC_IDLE;
      vs_p0          <= SYNC_IDLE;
    end else begin
      pixel_x        <= x_next;
      pixel_y        <= y_next;
      vga_valid_pre3 <= valid_next;
      frame_start    <= fs_next;
      hs_p0          <= hs_next;
      vs_p0          <= vs_next;
    end
  end

  // Each delay stage takes its input from the P0 flags or the previous stage.
  generate
    for (genvar gi = 0; gi < PIPE_DLY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign de_in[gi] = vga_valid_pre3;
        assign hs_in[gi] = hs_p0;
        assign vs_in[gi] = vs_p0;
      end else begin : g_body
        assign de_in[gi] = de_pipe[gi-1];
        assign hs_in[gi] = hs_pipe[gi-1];
        assign vs_in[gi] = vs_pipe[gi-1];
      end
    end
  endgenerate

  // Delay line; every stage resets idle so nothing spurious leaves the block
  // while the pipe refills after reset.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_pipe <= '0;
      hs_pipe <= {PIPE_DLY{SYNC_IDLE}};
      vs_pipe <= {PIPE_DLY{SYNC_IDLE}};
    end else begin
      de_pipe <= de_in;
      hs_pipe <= hs_in;
      vs_pipe <= vs_in;
    end
  end

  assign vga_de    = de_pipe[PIPE_DLY-1];
  assign vga_hsync = hs_pipe[PIPE_DLY-1];
  assign vga_vsync = vs_pipe[PIPE_DLY-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen, run on a reduced raster
// (32 x 19 clocks, 16 x 12 active) so several whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 8, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int PD = 3;
  localparam int HT = HA + HF + HS + HB;   // 32
  localparam int VT = VA + VF + VS + VB;   // 19
  localparam int FRAME = HT * VT;          // 608

  logic       vga_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       vga_valid_pre3;
  logic       frame_start;
  logic       vga_de;
  logic       vga_hsync;
  logic       vga_vsync;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0),  .PIPE_DLY(PD)
  ) dut (
    .vga_clk       (vga_clk),
    .rst_n         (rst_n),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .vga_valid_pre3(vga_valid_pre3),
    .frame_start   (frame_start),
    .vga_de        (vga_de),
    .vga_hsync     (vga_hsync),
    .vga_vsync     (vga_vsync)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } disp_t;

  disp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Reference raster position (what P0 should show after each edge).
  int mx, my;

  // Run-length and frame bookkeeping.
  int  line_run, hs_run, vs_run;
  int  frame_cyc, frame_valid;
  bit  seen_fs;
  int  since_rel;
  bit  de_seen;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (model x=%0d y=%0d)", tag, got, exp, mx, my);
    end
  endtask

  // Reference state after reset: parked on last pixel, delay line idle.
  task automatic model_reset();
    disp_t idle;
    idle = '{de: 1'b0, hs: 1'b1, vs: 1'b1};
    mx = HT - 1;
    my = VT - 1;
    sb_q.delete();
    for (int i = 0; i < PD; i++) sb_q.push_back(idle);
    line_run = 0; hs_run = 0; vs_run = 0;
    frame_cyc = 0; frame_valid = 0; seen_fs = 0;
    since_rel = 0; de_seen = 0;
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_pixel_x"}, int'(pixel_x), HT - 1);
    check({phase, "_pixel_y"}, int'(pixel_y), VT - 1);
    check({phase, "_valid_pre3"}, int'(vga_valid_pre3), 0);
    check({phase, "_frame_start"}, int'(frame_start), 0);
    check({phase, "_de"}, int'(vga_de), 0);
    check({phase, "_hsync"}, int'(vga_hsync), 1);
    check({phase, "_vsync"}, int'(vga_vsync), 1);
  endtask

  // One clock: advance the reference, check P0, push the P0 display triple,
  // pop the one due at the display side and compare.
  task automatic step();
    disp_t exp_p0, exp_out;
    int    ev, ef;
    @(posedge vga_clk);
    #1;
    since_rel++;
    if (mx == HT - 1) begin
      mx = 0;
      my = (my == VT - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
    ev = (mx < HA && my < VA) ? 1 : 0;
    ef = (mx == 0 && my == 0) ? 1 : 0;
    exp_p0.de = ev[0];
    exp_p0.hs = !(mx >= 20 && mx <= 27);   // 16+4 .. 16+4+8-1, active-low
    exp_p0.vs = !(my >= 14 && my <= 15);   // 12+2 .. 12+2+2-1, active-low

    check("pixel_x", int'(pixel_x), mx);
    check("pixel_y", int'(pixel_y), my);
    check("valid_pre3", int'(vga_valid_pre3), ev);
    check("frame_start", int'(frame_start), ef);

    sb_q.push_back(exp_p0);
    exp_out = sb_q.pop_front();
    check("vga_de", int'(vga_de), int'(exp_out.de));
    check("vga_hsync", int'(vga_hsync), int'(exp_out.hs));
    check("vga_vsync", int'(vga_vsync), int'(exp_out.vs));

    if (!de_seen && vga_de) begin
      de_seen = 1;
      check("first_de_after_release", since_rel, PD + 1);
    end

    if (vga_valid_pre3) begin
      line_run++;
    end else if (line_run != 0) begin
      check("line_valid_run", line_run, HA);
      line_run = 0;
    end
    if (!vga_hsync) begin
      hs_run++;
    end else if (hs_run != 0) begin
      check("hsync_low_width", hs_run, HS);
      hs_run = 0;
    end
    if (!vga_vsync) begin
      vs_run++;
    end else if (vs_run != 0) begin
      check("vsync_low_width", vs_run, VS * HT);
      vs_run = 0;
    end

    if (frame_start) begin
      if (seen_fs) begin
        check("frame_period", frame_cyc, FRAME);
        check("frame_valid_count", frame_valid, HA * VA);
      end
      seen_fs = 1;
      frame_cyc = 0;
      frame_valid = 0;
    end
    frame_cyc++;
    if (vga_valid_pre3) frame_valid++;
  endtask

  initial begin
    int guard;
    model_reset();

    // Reset held for 5 clocks, then released between edges.
    repeat (5) begin
      @(negedge vga_clk);
      check_reset_outputs("reset");
    end
    @(negedge vga_clk);
    rst_n = 1'b1;
    $display("phase: release, running 3 frames");
    repeat (3 * FRAME + 5) step();

    // Walk to an active pixel mid-frame with de already high.
    guard = 0;
    while (!(mx == 10 && my == 6) && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    check("reach_mid_frame", (mx == 10 && my == 6) ? 1 : 0, 1);
    #2;
    check("mid_de_before_reset", int'(vga_de), 1);
    $display("phase: asynchronous reset at x=%0d y=%0d", mx, my);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    repeat (3) begin
      @(negedge vga_clk);
      check_reset_outputs("reheld");
    end
    @(negedge vga_clk);
    rst_n = 1'b1;
    $display("phase: restart, running 2 frames");
    repeat (2 * FRAME + 5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
